// File: rtl/dm_access_unit.sv
// Load/store unit between the CPU datapath and a big-endian byte-array data memory.
// Sub-word stores are read-modify-write; rejected accesses never reach the memory.
module dm_access_unit #(
  parameter int MEM_BYTES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic [1:0]  state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        accept;
  logic        req_err;
  logic [31:0] req_aligned;

  // Lane k of a big-endian word occupies bits [31-8k -: 8].
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: r = uns ? {24'h0, b} : 32'(b);
      SZ_HALF: r = uns ? {16'h0, h} : 32'(h);
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    if (size == SZ_HALF) begin
      if (lane[1]) r[15:0]  = wd;
      else         r[31:16] = wd;
    end else begin
      case (lane)
        2'd0:    r[31:24] = wd[7:0];
        2'd1:    r[23:16] = wd[7:0];
        2'd2:    r[15:8]  = wd[7:0];
        default: r[7:0]   = wd[7:0];
      endcase
    end
    return r;
  endfunction

  function automatic logic access_error(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [31:0] aligned);
    logic e;
    e = (size == 2'b11)
      | ((size == SZ_HALF) & addr[0])
      | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
      | (aligned >= MEM_LIMIT);
    return e;
  endfunction

  assign req_aligned  = {i_req_addr[31:2], 2'b00};
  assign req_err      = access_error(i_req_size, i_req_addr, req_aligned);
  assign o_req_ready  = (state == S_IDLE);
  assign o_resp_valid = (state == S_RESP);
  // Decoded straight from state so an async reset kills the strobe mid-cycle.
  assign o_mem_write  = (state == S_WR);
  assign accept       = i_req_valid & o_req_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      o_resp_rdata <= 32'h0;
      o_resp_err   <= 1'b0;
      o_mem_addr   <= 32'h0;
      o_mem_wdata  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q         <= i_req_we;
            uns_q        <= i_req_unsigned;
            size_q       <= i_req_size;
            lane_q       <= i_req_addr[1:0];
            wdata_q      <= i_req_wdata[15:0];
            o_resp_rdata <= 32'h0;
            o_resp_err   <= req_err;
            if (req_err) begin
              state <= S_RESP;
            end else begin
              o_mem_addr <= req_aligned;
              // Full-word stores skip the read; nothing to merge.
              if (i_req_we && (i_req_size == SZ_WORD)) begin
                o_mem_wdata <= i_req_wdata;
                state       <= S_WR;
              end else begin
                state <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (we_q) begin
            o_mem_wdata <= store_merge(i_mem_rdata, wdata_q, size_q, lane_q);
            state       <= S_WR;
          end else begin
            o_resp_rdata <= load_extend(i_mem_rdata, size_q, lane_q, uns_q);
            state        <= S_RESP;
          end
        end
        S_WR: begin
          state <= S_RESP;
        end
        S_RESP: begin
          if (i_resp_ready) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
